serial2tcp_loopback_core: RTL and testbench
===========================================

Name: serial2tcp_loopback_core

Overview:
Byte-stream loopback endpoint for the serial2tcp simulation bridge. Every byte accepted on the sink stream is buffered in an in-order FIFO and re-emitted unchanged on the source stream. Both streams use valid/ready handshakes. It gives the TCP-side bridge a self-contained echo target for bring-up and simulation.

Parameters:
- DATA_WIDTH, 8, width of the stream payload in bits.
- DEPTH, 16, FIFO capacity in entries. Must be a power of two and at least 2.
- CNT_WIDTH, 32, width of the rx/tx byte counters.

Ports:
- sys_clk  in  1  sole clock; all logic is rising-edge.
- sys_rst  in  1  synchronous, active-high reset.
- serial2tcp_source_valid  out  1  looped-back byte available.
- serial2tcp_source_ready  in  1  downstream accepts the source byte.
- serial2tcp_source_data  out  DATA_WIDTH  looped-back byte.
- serial2tcp_sink_valid  in  1  upstream presents a byte.
- serial2tcp_sink_ready  out  1  block can accept a byte.
- serial2tcp_sink_data  in  DATA_WIDTH  incoming byte.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- rx_count  out  CNT_WIDTH  total bytes accepted on sink; wraps.
- tx_count  out  CNT_WIDTH  total bytes delivered on source; wraps.

Behaviour:
- Reset is synchronous and active-high.
  - While sys_rst is high at a rising edge, the following clear to 0: read/write pointers, level, rx_count, tx_count, source_valid.
  - Storage contents are don't-care.
  - sink_ready is 0 while sys_rst is high. No transfer is recorded in a cycle where sys_rst is high.
- Reset mid-operation: buffered bytes are discarded. After sys_rst deasserts, the first byte emitted on the source is the first byte accepted after reset.
- Sink handshake:
  - A push occurs on an edge where sink_valid && sink_ready.
  - sink_ready = !sys_rst && (level != DEPTH).
  - sink_ready depends only on registered state and sys_rst, never on source_ready (no combinational ready-to-ready path).
- Source handshake:
  - A pop occurs on an edge where source_valid && source_ready.
  - source_valid = (level != 0), and is low during reset.
  - source_data equals the oldest stored byte.
  - While source_valid is high and source_ready is low, source_valid and source_data hold stable.
- Latency:
  - A byte pushed at edge N is visible on the source at edge N+1 when the FIFO was empty (first-word fall-through from registered storage).
  - There is no same-cycle sink-to-source combinational path.
- Ordering: strictly FIFO. Data is bit-exact; no transformation.
- Occupancy update per edge:
  - push only: level+1.
  - pop only: level-1.
  - push and pop together: level unchanged. Both transfers occur and the pointers advance independently.
- Full: level == DEPTH, so sink_ready = 0. A pop in this cycle does not enable a same-cycle push; sink_ready rises on the next cycle.
- Empty: level == 0, so source_valid = 0. A push in this cycle does not produce same-cycle output.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. The full/empty distinction comes from level, not from pointer equality.
- Counters:
  - rx_count increments on each push; tx_count increments on each pop. Both wrap modulo 2^CNT_WIDTH.
  - Invariant outside reset: rx_count - tx_count == level (mod 2^CNT_WIDTH).
- Input X/garbage on sink_data is stored only when a push occurs.

Test Plan:
- Reset: hold sys_rst 3 cycles with sink_valid=1. Required: source_valid=0, sink_ready=0, level=0, rx_count=0, tx_count=0. One cycle after release, sink_ready=1 and nothing has been stored.
- Single echo: with source_ready=1, push 0xA5 at edge N. Required: source_valid=1 and source_data=0xA5 after edge N. Pop at edge N+1; level returns to 0; rx_count=1, tx_count=1.
- Fill/full: with source_ready=0, push 0x00..0x0F (DEPTH=16). Required: level=16 and sink_ready=0. A 17th byte 0x10 is held off and not stored. Then with source_ready=1, 0x00..0x0F drain in order, and 0x10 is accepted once sink_ready returns.
- Backpressure stability: push 0x11, 0x22; toggle source_ready randomly. Required: source_data stays constant while valid && !ready. Output sequence is exactly 0x11, 0x22.
- Simultaneous push/pop: with level=5, sink_valid=1 and source_ready=1 for 100 cycles using an incrementing pattern. Required: level stays 5, output equals input delayed by 5 transfers, and pointers wrap DEPTH multiple times without error.
- Mid-stream reset: with level=7, pulse sys_rst 1 cycle, then push 0x5A. Required: first source byte is 0x5A and the counters restart from 0.

Source files
------------

// File: rtl/serial2tcp_loopback_core.sv
// Byte-stream loopback endpoint: every byte accepted on the sink is buffered in
// an in-order FIFO and re-emitted unchanged on the source.
module serial2tcp_loopback_core #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  output logic                       serial2tcp_source_valid,
  input  logic                       serial2tcp_source_ready,
  output logic [DATA_WIDTH-1:0]      serial2tcp_source_data,
  input  logic                       serial2tcp_sink_valid,
  output logic                       serial2tcp_sink_ready,
  input  logic [DATA_WIDTH-1:0]      serial2tcp_sink_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       rx_count,
  output logic [CNT_WIDTH-1:0]       tx_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [CNT_WIDTH-1:0]  rx_count_q, rx_count_d;
  logic [CNT_WIDTH-1:0]  tx_count_q, tx_count_d;
  logic                  push, pop;

  // Handshake flags come only from registered level and reset, so there is no
  // combinational path from source_ready to sink_ready or from sink to source.
  always_comb begin
    serial2tcp_sink_ready   = !sys_rst && (level_q != FULL_LEVEL);
    serial2tcp_source_valid = !sys_rst && (level_q != '0);
    serial2tcp_source_data  = mem_q[rd_ptr_q];
    push = serial2tcp_sink_valid && serial2tcp_sink_ready;
    pop  = serial2tcp_source_valid && serial2tcp_source_ready;
    level    = level_q;
    rx_count = rx_count_q;
    tx_count = tx_count_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      rx_count_d = rx_count_q + CNT_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      tx_count_d = tx_count_q + CNT_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  // Storage is not reset; push is already gated off while sys_rst is high.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= serial2tcp_sink_data;
    end
  end

endmodule

// File: tb/tb_serial2tcp_loopback_core.sv
// Testbench for serial2tcp_loopback_core: directed and random traffic checked
// against a queue-based reference model of the loopback FIFO.
module tb_serial2tcp_loopback_core;

   localparam int DEPTH = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        sourceValid;
   logic        sourceReady;
   logic [7:0]  sourceData;
   logic        sinkValid;
   logic        sinkReady;
   logic [7:0]  sinkData;
   logic [4:0]  level;
   logic [31:0] rxCount;
   logic [31:0] txCount;

   logic [7:0]  modelQ[$];
   logic [7:0]  popLog[$];
   logic [31:0] modelRx;
   logic [31:0] modelTx;
   bit          curRst;
   bit          curSv;
   bit          curSr;
   logic [7:0]  curSd;
   int          total = 0;
   int          bad = 0;

   serial2tcp_loopback_core dut (
      .sys_clk                 (sys_clk),
      .sys_rst                 (sys_rst),
      .serial2tcp_source_valid (sourceValid),
      .serial2tcp_source_ready (sourceReady),
      .serial2tcp_source_data  (sourceData),
      .serial2tcp_sink_valid   (sinkValid),
      .serial2tcp_sink_ready   (sinkReady),
      .serial2tcp_sink_data    (sinkData),
      .level                   (level),
      .rx_count                (rxCount),
      .tx_count                (txCount)
   );

   // Free-running 10-unit clock; inputs change on the falling edge.
   always #5 sys_clk = ~sys_clk;

   // Single comparison point: counts the check and reports any disagreement.
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives the DUT inputs and remembers them for the reference model.
   task automatic applyStimulus(input bit rst, input bit sv, input logic [7:0] sd, input bit sr);
      sys_rst     = rst;
      sinkValid   = sv;
      sinkData    = sd;
      sourceReady = sr;
      curRst = rst;
      curSv  = sv;
      curSd  = sd;
      curSr  = sr;
   endtask

   // Compares every visible output against the model state before the edge.
   task automatic checkOutput();
      bit expReady;
      bit expValid;
      expReady = !curRst && (modelQ.size() != DEPTH);
      expValid = !curRst && (modelQ.size() != 0);
      checkVal("sink_ready", 32'(sinkReady), 32'(expReady));
      checkVal("source_valid", 32'(sourceValid), 32'(expValid));
      if (expValid) checkVal("source_data", 32'(sourceData), 32'(modelQ[0]));
      checkVal("level", 32'(level), 32'(modelQ.size()));
      checkVal("rx_count", rxCount, modelRx);
      checkVal("tx_count", txCount, modelTx);
   endtask

   // Reference FIFO behaviour at a rising edge, decided from pre-edge state.
   task automatic modelEdge();
      bit doPush;
      bit doPop;
      if (curRst) begin
         modelQ.delete();
         modelRx = '0;
         modelTx = '0;
      end else begin
         doPush = curSv && (modelQ.size() != DEPTH);
         doPop  = curSr && (modelQ.size() != 0);
         if (doPop) begin
            popLog.push_back(modelQ.pop_front());
            modelTx = modelTx + 32'd1;
         end
         if (doPush) begin
            modelQ.push_back(curSd);
            modelRx = modelRx + 32'd1;
         end
      end
   endtask

   // One full clock: drive, check pre-edge outputs, clock, update model.
   task automatic cycle(input bit rst, input bit sv, input logic [7:0] sd, input bit sr, input bit chk);
      applyStimulus(rst, sv, sd, sr);
      #1;
      if (chk) checkOutput();
      @(posedge sys_clk);
      modelEdge();
      @(negedge sys_clk);
   endtask

   initial begin
      logic [7:0] heldData;
      bit         held;
      int         pushIdx;
      modelRx = '0;
      modelTx = '0;

      // Reset held three cycles with a byte offered; nothing may be taken.
      cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkVal("post_reset_level", 32'(level), 32'd0);
      checkVal("post_reset_ready", 32'(sinkReady), 32'd1);

      // Single echo with first-word fall-through.
      cycle(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
      checkVal("echo_valid", 32'(sourceValid), 32'd1);
      checkVal("echo_data", 32'(sourceData), 32'hA5);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkVal("echo_level", 32'(level), 32'd0);
      checkVal("echo_rx", rxCount, 32'd1);
      checkVal("echo_tx", txCount, 32'd1);

      // Fill to full, offer a 17th byte, then drain in order.
      popLog.delete();
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
      checkVal("full_level", 32'(level), 32'd16);
      checkVal("full_ready", 32'(sinkReady), 32'd0);
      cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b1);
      checkVal("full_hold_level", 32'(level), 32'd16);
      cycle(1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
      checkVal("full_ready_after_pop", 32'(sinkReady), 32'd1);
      cycle(1'b0, 1'b1, 8'h10, 1'b1, 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkVal("drain_count", 32'(popLog.size()), 32'd17);
      if (popLog.size() == 17)
         for (int i = 0; i < 17; i++) checkVal("drain_order", 32'(popLog[i]), 32'(i));

      // Backpressure: random source_ready, output must hold while stalled.
      popLog.delete();
      pushIdx = 0;
      for (int i = 0; i < 200 && popLog.size() < 2; i++) begin
         bit sr;
         sr = 1'($urandom_range(0, 1));
         held = (modelQ.size() != 0) && !sr;
         heldData = held ? modelQ[0] : 8'h00;
         if (pushIdx < 2) begin
            cycle(1'b0, 1'b1, (pushIdx == 0) ? 8'h11 : 8'h22, sr, 1'b1);
            pushIdx++;
         end else begin
            cycle(1'b0, 1'b0, 8'h00, sr, 1'b1);
         end
         if (held) checkVal("bp_stable", 32'(sourceData), 32'(heldData));
      end
      checkVal("bp_count", 32'(popLog.size()), 32'd2);
      if (popLog.size() == 2) begin
         checkVal("bp_first", 32'(popLog[0]), 32'h11);
         checkVal("bp_second", 32'(popLog[1]), 32'h22);
      end

      // Simultaneous push/pop at level 5 across several pointer wraps.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
      checkVal("sim_level_start", 32'(level), 32'd5);
      for (int i = 0; i < 100; i++) begin
         cycle(1'b0, 1'b1, 8'(8'h35 + i), 1'b1, 1'b1);
         checkVal("sim_level", 32'(level), 32'd5);
         checkVal("sim_delay", 32'(sourceData), 32'(8'(8'h31 + i)));
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++)
         cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);

      // Mid-stream reset with seven bytes buffered.
      for (int i = 0; i < 400 && modelQ.size() != 0; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b1);
      checkVal("mid_level", 32'(level), 32'd7);
      cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
      popLog.delete();
      cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
      checkVal("mid_first_data", 32'(sourceData), 32'h5A);
      checkVal("mid_rx", rxCount, 32'd1);
      checkVal("mid_tx", txCount, 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checkVal("mid_pop_count", 32'(popLog.size()), 32'd1);
      if (popLog.size() == 1) checkVal("mid_pop_data", 32'(popLog[0]), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
